// File: rtl/rsa_key_gen.sv
// RSA key generation: n, phi and d = e^-1 mod phi by iterative extended Euclid.
// Optional (e*d) mod phi self-check enabled by RSA_KEYGEN_SELFCHECK_EN.
module rsa_key_gen #(
    parameter int W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [W-1:0]   p,
    input  logic [W-1:0]   q,
    input  logic [W-1:0]   e,
    output logic           busy,
    output logic           finished,
    output logic           key_ok,
    output logic [2*W-1:0] n,
    output logic [2*W-1:0] phi,
    output logic [2*W-1:0] d,
    output logic           check_err
);

    localparam int DW = 2 * W;
`ifdef RSA_KEYGEN_SELFCHECK_EN
    localparam int QW = 4 * W;
`else
    localparam int QW = DW;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_UPDATE,
        S_FINAL,
`ifdef RSA_KEYGEN_SELFCHECK_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_p, r_q, r_e;
    logic [DW-1:0]      r_n, r_phi;
    logic [DW-1:0]      r_r0, r_r1;
    logic signed [DW:0] r_t0, r_t1;
    logic [QW-1:0]      r_quo;
    logic [DW-1:0]      r_rem;
    logic [5:0]         r_cnt;
    logic               r_busy, r_finished, r_key_ok;
    logic [DW-1:0]      r_out_n, r_out_phi, r_out_d;

    logic [W-1:0]       w_pm1, w_qm1;
    logic [DW-1:0]      w_n, w_phi, w_d;
    logic               w_legal, w_r0_one;
    logic [DW:0]        w_sh, w_diff;
    logic               w_ge;
    logic signed [DW:0] w_prod, w_t1n;
    logic               w_fin, w_fin_ok;
    logic [DW-1:0]      w_fin_d, w_fin_n, w_fin_phi;

    assign w_pm1    = r_p - W'(1);
    assign w_qm1    = r_q - W'(1);
    assign w_n      = DW'(r_p) * DW'(r_q);
    assign w_phi    = DW'(w_pm1) * DW'(w_qm1);
    assign w_legal  = (r_p >= W'(2)) && (r_q >= W'(2)) &&
                      (r_e > W'(1)) && (DW'(r_e) < w_phi);
    assign w_r0_one = (r_r0 == DW'(1));

    // One restoring-divider step; divisor is always r_r1.
    assign w_sh   = {r_rem, r_quo[QW-1]};
    assign w_diff = w_sh - {1'b0, r_r1};
    assign w_ge   = ~w_diff[DW];

    // t arithmetic wraps mod 2^(DW+1); the true results always fit.
    assign w_prod = $signed({1'b0, r_quo[DW-1:0]}) * r_t1;
    assign w_t1n  = r_t0 - w_prod;
    assign w_d    = r_t0[DW] ? (r_t0[DW-1:0] + r_phi) : r_t0[DW-1:0];

`ifdef RSA_KEYGEN_SELFCHECK_EN
    logic           r_check_err;
    logic [DW-1:0]  r_d;
    logic [QW-1:0]  w_ed;
    logic           w_fin_err;
    assign w_ed      = QW'(r_e) * QW'(w_d);
    assign check_err = r_check_err;
`else
    assign check_err = 1'b0;
`endif

    always_comb begin
        w_fin     = 1'b0;
        w_fin_ok  = 1'b0;
        w_fin_d   = '0;
        w_fin_n   = r_n;
        w_fin_phi = r_phi;
`ifdef RSA_KEYGEN_SELFCHECK_EN
        w_fin_err = 1'b0;
`endif
        if (r_state == S_LOAD && !w_legal) begin
            w_fin     = 1'b1;
            w_fin_n   = w_n;
            w_fin_phi = w_phi;
`ifdef RSA_KEYGEN_SELFCHECK_EN
        end else if (r_state == S_FINAL && !w_r0_one) begin
            w_fin = 1'b1;
        end else if (r_state == S_CHECK && r_cnt == 6'(QW)) begin
            w_fin     = 1'b1;
            w_fin_ok  = (r_rem == DW'(1));
            w_fin_d   = w_fin_ok ? r_d : '0;
            w_fin_err = !w_fin_ok;
`else
        end else if (r_state == S_FINAL) begin
            w_fin    = 1'b1;
            w_fin_ok = w_r0_one;
            w_fin_d  = w_r0_one ? w_d : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_p        <= '0;
            r_q        <= '0;
            r_e        <= '0;
            r_n        <= '0;
            r_phi      <= '0;
            r_r0       <= '0;
            r_r1       <= '0;
            r_t0       <= '0;
            r_t1       <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_key_ok   <= 1'b0;
            r_out_n    <= '0;
            r_out_phi  <= '0;
            r_out_d    <= '0;
`ifdef RSA_KEYGEN_SELFCHECK_EN
            r_check_err <= 1'b0;
            r_d         <= '0;
`endif
        end else begin
            r_finished <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_p     <= p;
                        r_q     <= q;
                        r_e     <= e;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_n   <= w_n;
                    r_phi <= w_phi;
                    if (w_legal) begin
                        r_r0    <= w_phi;
                        r_r1    <= DW'(r_e);
                        r_t0    <= '0;
                        r_t1    <= (DW+1)'(1);
                        r_quo   <= QW'(w_phi) << (QW - DW);
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff[DW-1:0] : w_sh[DW-1:0];
                    r_quo <= {r_quo[QW-2:0], w_ge};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(DW - 1))
                        r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_r0    <= r_r1;
                    r_r1    <= r_rem;
                    r_t0    <= r_t1;
                    r_t1    <= w_t1n;
                    r_quo   <= QW'(r_r1) << (QW - DW);
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_state <= (r_rem != '0) ? S_DIV : S_FINAL;
                end
                S_FINAL: begin
`ifdef RSA_KEYGEN_SELFCHECK_EN
                    if (w_r0_one) begin
                        r_d     <= w_d;
                        r_quo   <= w_ed;
                        r_r1    <= r_phi;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CHECK;
                    end
`endif
                end
`ifdef RSA_KEYGEN_SELFCHECK_EN
                S_CHECK: begin
                    if (r_cnt != 6'(QW)) begin
                        r_rem <= w_ge ? w_diff[DW-1:0] : w_sh[DW-1:0];
                        r_quo <= {r_quo[QW-2:0], w_ge};
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
`endif
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_fin) begin
                r_out_n    <= w_fin_n;
                r_out_phi  <= w_fin_phi;
                r_out_d    <= w_fin_d;
                r_key_ok   <= w_fin_ok;
                r_finished <= 1'b1;
                r_busy     <= 1'b0;
                r_state    <= S_DONE;
`ifdef RSA_KEYGEN_SELFCHECK_EN
                r_check_err <= w_fin_err;
`endif
            end
        end
    end

    assign busy     = r_busy;
    assign finished = r_finished;
    assign key_ok   = r_key_ok;
    assign n        = r_out_n;
    assign phi      = r_out_phi;
    assign d        = r_out_d;

endmodule

// File: tb/tb_rsa_key_gen.sv
// Randomised bench for rsa_key_gen against a plain-arithmetic RSA model.
// Covers reset, nominal/illegal keys, busy protection, back-to-back, mid-run reset.
module tb_rsa_key_gen;

    localparam int W  = 12;
    localparam int DW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [W-1:0]  p = '0, q = '0, e = '0;
    logic          busy, finished, key_ok, check_err;
    logic [DW-1:0] n, phi, d;

    int total = 0;
    int bad   = 0;
    int intr_at = -1;
    int ip, iq, ie;

    rsa_key_gen #(.W(W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .p(p), .q(q), .e(e),
        .busy(busy), .finished(finished), .key_ok(key_ok),
        .n(n), .phi(phi), .d(d), .check_err(check_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Textbook RSA: modular inverse by extended Euclid on integers.
    task automatic model(input int pp, qq, ee,
                         output longint mn, mphi, md,
                         output int mok, mlat);
        longint a, b, r, qt, s0, s1, tmp;
        int k;
        mn   = longint'(pp) * qq;
        mphi = longint'(pp - 1) * (qq - 1);
        md   = 0;
        mok  = 0;
        mlat = 2;
        if (pp >= 2 && qq >= 2 && ee > 1 && ee < mphi) begin
            a = mphi; b = ee; s0 = 0; s1 = 1; k = 0;
            while (b != 0) begin
                qt  = a / b;
                r   = a % b;
                a   = b;
                b   = r;
                tmp = s0 - qt * s1;
                s0  = s1;
                s1  = tmp;
                k++;
            end
            mok  = (a == 1) ? 1 : 0;
            mlat = 3 + k * (2 * DW / 2 + 1);
            if (mok == 1) begin
                md = s0 % mphi;
                if (md < 0) md += mphi;
`ifdef RSA_KEYGEN_SELFCHECK_EN
                mlat += 4 * W + 1;
`endif
            end
        end
    endtask

    task automatic run_job(input int pp, qq, ee, input bit b2b,
                           output int cyc, output int gaps);
        p = pp[W-1:0];
        q = qq[W-1:0];
        e = ee[W-1:0];
        enable = 1'b1;
        if (b2b) @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        cyc  = 1;
        gaps = 0;
        while (cyc <= 6000) begin
            if (cyc == 1) begin
                p = W'($urandom);
                q = W'($urandom);
                e = W'($urandom);
            end
            if (cyc == intr_at) begin
                enable = 1'b1;
                p = ip[W-1:0];
                q = iq[W-1:0];
                e = ie[W-1:0];
            end else if (cyc == intr_at + 1) begin
                enable = 1'b0;
            end
            if (finished) break;
            if (!busy) gaps++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_job(input string tag, input int pp, qq, ee,
                             input int cyc, gaps);
        longint mn, mphi, md;
        int mok, mlat;
        model(pp, qq, ee, mn, mphi, md, mok, mlat);
        chk({tag, ".lat"}, cyc, mlat);
        chk({tag, ".n"}, n, mn);
        chk({tag, ".phi"}, phi, mphi);
        chk({tag, ".d"}, d, md);
        chk({tag, ".ok"}, key_ok, mok);
        chk({tag, ".err"}, check_err, 0);
        chk({tag, ".busyfin"}, busy, 0);
        chk({tag, ".gaps"}, gaps, 0);
    endtask

    task automatic job(input string tag, input int pp, qq, ee, input bit b2b);
        int cyc, gaps;
        run_job(pp, qq, ee, b2b, cyc, gaps);
        check_job(tag, pp, qq, ee, cyc, gaps);
    endtask

    initial begin
        int fins, bz, rp, rq, re, ph;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fins = 0;
        bz = 0;
        repeat (10) begin
            if (finished) fins++;
            if (busy) bz++;
            @(negedge clk);
        end
        chk("idle.fin", fins, 0);
        chk("idle.busy", bz, 0);
        chk("idle.n", n, 0);
        chk("idle.phi", phi, 0);
        chk("idle.d", d, 0);
        chk("idle.ok", key_ok, 0);
        chk("idle.err", check_err, 0);

        job("nominal", 61, 53, 17, 1'b0);
        job("coprime_no", 61, 53, 15, 1'b1);
        job("e_one", 61, 53, 1, 1'b1);
        job("e_phi", 61, 53, 3120, 1'b1);
        job("p_one", 1, 53, 17, 1'b1);

        intr_at = 20;
        ip = 3; iq = 11; ie = 7;
        job("busy_prot", 61, 53, 17, 1'b1);
        intr_at = -1;
        job("b2b", 3, 11, 7, 1'b1);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(3) == 0) begin
                rp = $urandom_range(1, 4095);
                rq = $urandom_range(1, 4095);
            end else begin
                rp = $urandom_range(2, 300);
                rq = $urandom_range(2, 300);
            end
            ph = (rp - 1) * (rq - 1);
            if ($urandom_range(3) == 0 || ph < 3)
                re = $urandom_range(0, 4095);
            else
                re = $urandom_range(2, (ph - 1 > 4095) ? 4095 : ph - 1);
            job($sformatf("rnd%0d", i), rp, rq, re, 1'b1);
        end

        @(negedge clk);
        p = 12'd61; q = 12'd53; e = 12'd17;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        fins = 0;
        for (int c = 1; c < 40; c++) begin
            if (finished) fins++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bz = 0;
        repeat (120) begin
            if (finished) fins++;
            if (busy) bz++;
            @(negedge clk);
        end
        chk("rst.fin", fins, 0);
        chk("rst.busy", bz, 0);
        chk("rst.n", n, 0);
        chk("rst.phi", phi, 0);
        chk("rst.d", d, 0);
        chk("rst.ok", key_ok, 0);
        job("after_rst", 61, 53, 17, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_key_gen.md
# rsa_key_gen

- Key-generation stage directly downstream of the prime lookup table.
- Accepts the two primes p, q and a candidate public exponent e, and computes modulus n = p·q and totient phi = (p−1)(q−1).
- Runs iterative extended Euclid, with a shared restoring divider, to produce private exponent d = e⁻¹ mod phi, plus a key_ok flag.
- Results feed the decryption stage.

## Interface
- W, 12, width of p, q, e; n, phi, d are 2W bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  start request, sampled only in IDLE
- p  in  W  first prime, captured when enable accepted
- q  in  W  second prime, captured when enable accepted
- e  in  W  candidate public exponent, captured when enable accepted
- busy  out  1  high from the cycle after acceptance until finished
- finished  out  1  one-cycle pulse, results valid
- key_ok  out  1  1 = gcd(e,phi)=1 and inputs legal
- n  out  2W  p·q
- phi  out  2W  (p−1)(q−1)
- d  out  2W  private exponent; 0 when key_ok=0
- check_err  out  1  self-check mismatch (see Configuration)

## Operation
- States: IDLE, LOAD, DIV, UPDATE, FINAL, DONE (+ CHECK with macro).
- IDLE:
  - enable=1 captures p, q, e and goes to LOAD.
  - enable is ignored in every other state.
- LOAD (1 cycle):
  - Registers n and phi (full-width products).
  - Range check: p≥2, q≥2, 1<e<phi. Failure goes to DONE with key_ok=0, d=0.
  - Otherwise initialises r0=phi, r1=e, t0=0, t1=1 and goes to DIV.
- DIV (2W cycles):
  - Restoring shift-subtract computes quotient qt=r0/r1 and remainder rm.
  - One quotient bit per cycle, MSB first.
- UPDATE (1 cycle):
  - r0←r1, r1←rm, t0←t1, t1←t0−qt·t1.
  - t registers are 2W+1-bit two's complement; |t| ≤ phi always, so no overflow.
  - rm≠0 returns to DIV; rm=0 goes to FINAL.
- FINAL (1 cycle):
  - If r0==1: key_ok=1, d = t0<0 ? t0+phi : t0.
  - Else: key_ok=0, d=0.
- DONE (1 cycle):
  - Updates the n, phi, d, key_ok, check_err outputs and pulses finished.
  - Returns to IDLE.
- Outputs hold their values between finished pulses. They do not change when new inputs arrive or while busy.

## Timing
- Reset values: busy=0, finished=0, key_ok=0, n=0, phi=0, d=0, check_err=0; state=IDLE.
- Latency is counted from the enable-sampling edge, with k = number of Euclid quotient steps:
  - finished is high in cycle 3 + k·(2W+1) (legal inputs).
  - finished is high in cycle 2 (range-check failure).
- busy falls in the same cycle finished rises.
- Back-to-back: enable may be asserted in the cycle finished is high. It is accepted one cycle later, once in IDLE.
- Reset mid-operation: rst=1 on any edge forces IDLE and all reset values; the in-flight job is discarded with no finished pulse.
- Input changes after acceptance have no effect.

## Configuration
- RSA_KEYGEN_SELFCHECK_EN defined:
  - After FINAL with key_ok=1, state CHECK computes (e·d) mod phi.
  - CHECK uses a 4W-bit dividend and takes 4W cycles, adding exactly 4W+1 cycles to the latency.
  - A result ≠1 sets check_err=1 and forces key_ok=0.
- Undefined:
  - No CHECK state and no extra latency.
  - check_err is tied to 0.

## Test plan
- Reset/idle: hold rst 3 cycles, then enable=0 for 10 cycles -> all outputs 0, busy=0, no finished pulse.
- Nominal key: p=61, q=53, e=17, W=12 -> n=3233, phi=3120, d=2753, key_ok=1, check_err=0.
  - k=4, so finished in cycle 103 without the macro and cycle 152 with it.
- Non-coprime: p=61, q=53, e=15 -> n=3233, phi=3120, key_ok=0, d=0; finished in cycle 3+k·25.
- Illegal input: e=1, then e=3120, then p=1 (each a separate job) -> key_ok=0, d=0, finished in cycle 2 each time.
- Reset mid-run: start the nominal key, assert rst in cycle 40 -> no finished pulse, outputs 0.
  - A new enable afterwards completes normally with d=2753.
- Busy protection and back-to-back:
  - Pulse enable with p=3, q=11, e=7 in cycle 20 of the nominal job -> ignored; nominal results unchanged.
  - Then enable that same job in the finished cycle -> accepted, result n=33, phi=20, d=3, key_ok=1.
